// File: rtl/mem_bus_scheduler_pkg.sv
// Shared widths, memory op codes and scheduler state encoding for the
// icache/dcache memory-port scheduler.
package mem_bus_scheduler_pkg;

  localparam int DEFAULT_MEMORY_ADDRESS_SIZE = 32;
  localparam int DEFAULT_CACHE_LINE_SIZE     = 128;
  localparam int DEFAULT_MAX_WAIT            = 3;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mem_bus_scheduler_arb.sv
// Winner select between icache and dcache, with a saturating aging counter
// that forces an icache win after MAX_WAIT consecutive dcache wins.
module mem_arb_priority #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic icache_req,
  input  logic dcache_req,
  input  logic in_idle,
  input  logic arbitrate,
  output logic icache_wins
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          aged;

  assign aged        = (wait_cnt_q == CW'(MAX_WAIT));
  assign icache_wins = icache_req & (~dcache_req | aged);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (arbitrate) begin
      if (icache_wins || !icache_req) begin
        wait_cnt_d = '0;
      end else if (!aged) begin
        wait_cnt_d = wait_cnt_q + CW'(1);
      end
    end else if (in_idle && !icache_req) begin
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Shares the single main-memory port between icache (read-only) and dcache
// (read/write); one line transaction at a time, IDLE -> BUSY -> DONE.
//
//   state | meaning
//   IDLE  | port free, arbitrate on any request
//   BUSY  | transaction issued, waiting for mem_data_ready
//   DONE  | one-cycle data_ready pulse to the winner, grant still held
module mem_bus_scheduler
  import mem_bus_scheduler_pkg::*;
#(
  parameter int MEMORY_ADDRESS_SIZE = DEFAULT_MEMORY_ADDRESS_SIZE,
  parameter int CACHE_LINE_SIZE     = DEFAULT_CACHE_LINE_SIZE,
  parameter int MAX_WAIT            = DEFAULT_MAX_WAIT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           icache_req,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] icache_addr,
  output logic                           icache_grant,
  output logic                           icache_data_ready,
  input  logic                           dcache_req,
  input  logic                           dcache_op,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] dcache_addr,
  input  logic [CACHE_LINE_SIZE-1:0]     dcache_wdata,
  output logic                           dcache_grant,
  output logic                           dcache_data_ready,
  output logic                           mem_enable,
  output logic                           mem_op,
  output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
  output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
  input  logic                           mem_data_ready,
  input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
  output logic [CACHE_LINE_SIZE-1:0]     line_data_out
);

  sched_state_e                   state_q, state_d;
  logic                           icache_grant_q, icache_grant_d;
  logic                           dcache_grant_q, dcache_grant_d;
  logic                           icache_ready_q, icache_ready_d;
  logic                           dcache_ready_q, dcache_ready_d;
  logic                           mem_enable_q, mem_enable_d;
  logic                           mem_op_q, mem_op_d;
  logic [MEMORY_ADDRESS_SIZE-1:0] mem_address_q, mem_address_d;
  logic [CACHE_LINE_SIZE-1:0]     mem_data_in_q, mem_data_in_d;
  logic [CACHE_LINE_SIZE-1:0]     line_q, line_d;

  logic in_idle, arbitrate, icache_wins;

  assign in_idle   = (state_q == ST_IDLE);
  assign arbitrate = in_idle & (icache_req | dcache_req);

  mem_arb_priority #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .icache_req  (icache_req),
    .dcache_req  (dcache_req),
    .in_idle     (in_idle),
    .arbitrate   (arbitrate),
    .icache_wins (icache_wins)
  );

  always_comb begin
    state_d        = state_q;
    icache_grant_d = icache_grant_q;
    dcache_grant_d = dcache_grant_q;
    icache_ready_d = 1'b0;
    dcache_ready_d = 1'b0;
    mem_enable_d   = mem_enable_q;
    mem_op_d       = mem_op_q;
    mem_address_d  = mem_address_q;
    mem_data_in_d  = mem_data_in_q;
    line_d         = line_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arbitrate) begin
          state_d      = ST_BUSY;
          mem_enable_d = 1'b1;
          if (icache_wins) begin
            icache_grant_d = 1'b1;
            dcache_grant_d = 1'b0;
            mem_address_d  = icache_addr;
            mem_op_d       = MEM_OP_READ;
          end else begin
            icache_grant_d = 1'b0;
            dcache_grant_d = 1'b1;
            mem_address_d  = dcache_addr;
            mem_op_d       = dcache_op;
            mem_data_in_d  = dcache_wdata;
          end
        end
      end
      ST_BUSY: begin
        if (mem_data_ready) begin
          state_d        = ST_DONE;
          mem_enable_d   = 1'b0;
          icache_ready_d = icache_grant_q;
          dcache_ready_d = dcache_grant_q;
          // writes leave the shared read line untouched
          if (mem_op_q == MEM_OP_READ) line_d = mem_data_out;
        end
      end
      ST_DONE: begin
        state_d        = ST_IDLE;
        icache_grant_d = 1'b0;
        dcache_grant_d = 1'b0;
      end
      default: begin
        state_d        = ST_IDLE;
        icache_grant_d = 1'b0;
        dcache_grant_d = 1'b0;
        mem_enable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      icache_grant_q <= 1'b0;
      dcache_grant_q <= 1'b0;
      icache_ready_q <= 1'b0;
      dcache_ready_q <= 1'b0;
      mem_enable_q   <= 1'b0;
      mem_op_q       <= MEM_OP_READ;
      mem_address_q  <= '0;
      mem_data_in_q  <= '0;
      line_q         <= '0;
    end else begin
      state_q        <= state_d;
      icache_grant_q <= icache_grant_d;
      dcache_grant_q <= dcache_grant_d;
      icache_ready_q <= icache_ready_d;
      dcache_ready_q <= dcache_ready_d;
      mem_enable_q   <= mem_enable_d;
      mem_op_q       <= mem_op_d;
      mem_address_q  <= mem_address_d;
      mem_data_in_q  <= mem_data_in_d;
      line_q         <= line_d;
    end
  end

  assign icache_grant      = icache_grant_q;
  assign dcache_grant      = dcache_grant_q;
  assign icache_data_ready = icache_ready_q;
  assign dcache_data_ready = dcache_ready_q;
  assign mem_enable        = mem_enable_q;
  assign mem_op            = mem_op_q;
  assign mem_address       = mem_address_q;
  assign mem_data_in       = mem_data_in_q;
  assign line_data_out     = line_q;

endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
Clocked scheduler that shares the single main-memory port between the instruction cache (read-only) and the data cache (read/write).
- Accepts one line-sized transaction at a time and drives the memory handshake.
- Returns read data and a one-cycle completion pulse to the winning cache.
- Data cache has default priority; a saturating aging counter prevents instruction-cache starvation.
- Sits between the two cache controllers and the memory model.

Parameters:
MEMORY_ADDRESS_SIZE, 32, width of line addresses sent to memory
CACHE_LINE_SIZE, 128, width of a cache line transfer in bits
MAX_WAIT, 3, number of consecutive dcache wins while icache is waiting before icache is forced to win

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
icache_req  in  1  icache requests a line read; held until icache_data_ready
icache_addr  in  MEMORY_ADDRESS_SIZE  icache line address
icache_grant  out  1  icache owns the memory port
icache_data_ready  out  1  one-cycle pulse: read line valid on line_data_out
dcache_req  in  1  dcache requests a transaction; held until dcache_data_ready
dcache_op  in  1  0 = read, 1 = write
dcache_addr  in  MEMORY_ADDRESS_SIZE  dcache line address
dcache_wdata  in  CACHE_LINE_SIZE  line to write (op=1)
dcache_grant  out  1  dcache owns the memory port
dcache_data_ready  out  1  one-cycle pulse: read data valid / write acknowledged
mem_enable  out  1  memory transaction active
mem_op  out  1  0 = read, 1 = write
mem_address  out  MEMORY_ADDRESS_SIZE  address to memory
mem_data_in  out  CACHE_LINE_SIZE  write data to memory
mem_data_ready  in  1  memory completion, level, sampled on clk
mem_data_out  in  CACHE_LINE_SIZE  read data from memory
line_data_out  out  CACHE_LINE_SIZE  registered read line shared by both caches

Behaviour:
- Reset: rst sampled high → state IDLE.
  - All outputs 0: grants, data_ready pulses, mem_enable, mem_op, mem_address, mem_data_in, line_data_out.
  - wait_cnt = 0.
  - Reset mid-transaction abandons it; no data_ready pulse is issued.
- States: IDLE, BUSY, DONE (one-hot or 2-bit binary; encoding lives in the package).
- IDLE:
  - No request: stay.
  - Any request: select the winner and register it; next state BUSY.
  - At the same edge, register mem_address, mem_op, mem_data_in (dcache only; icache forces mem_op=0), set mem_enable=1 and the winner's grant=1.
  - Latency: request seen at edge N → mem_enable high after edge N.
- Winner selection:
  - Only one requester: it wins.
  - Both requesting: dcache wins unless wait_cnt == MAX_WAIT, in which case icache wins.
- wait_cnt:
  - +1 on each IDLE→BUSY where dcache wins while icache_req=1; saturates at MAX_WAIT.
  - Cleared when icache wins, or in IDLE whenever icache_req=0.
- BUSY:
  - mem_address, mem_op, mem_data_in and the grant are held stable.
  - On the edge where mem_data_ready=1: mem_enable ← 0; next state DONE.
  - Read: line_data_out ← mem_data_out at that edge.
  - Write: line_data_out unchanged.
- DONE (exactly one cycle):
  - Winner's data_ready = 1; grant still 1.
  - Next edge → IDLE with grant 0 and data_ready 0.
  - Requester drops req on that same edge.
  - req still high in the following IDLE cycle = a new request.
- Minimum transaction: 3 cycles (IDLE→BUSY→DONE) when mem_data_ready arrives the first BUSY cycle.
  - Back-to-back service: one transaction per 3 cycles minimum.
- mem_data_ready while in IDLE or DONE: ignored.
- req dropped while BUSY: transaction still completes and data_ready still pulses.
- Address/data changes on inputs during BUSY: ignored (registered copies used).
- Grants are mutually exclusive. The two data_ready outputs are never high together.

Decomposition:
- src/parameters.v (shared): MEMORY_ADDRESS_SIZE, CACHE_LINE_SIZE, MEM_OP_READ=0, MEM_OP_WRITE=1, scheduler state encodings, default MAX_WAIT.
- One sub-module, mem_arb_priority: winner select plus the wait_cnt aging counter.
  - Inputs: clk, rst, icache_req, dcache_req, arbitrate strobe (IDLE & any req).
  - Output: icache_wins.
- Top level holds the FSM and datapath registers.

Test Plan:
- icache_req=1, addr=0x40; memory answers 2 cycles after mem_enable with 0xDEAD...BEEF:
  - mem_op=0, mem_address=0x40.
  - icache_data_ready pulses 1 cycle with line_data_out=0xDEAD...BEEF.
  - icache_grant falls the cycle after.
- dcache write, addr=0x80, wdata=0x1234...:
  - mem_op=1, mem_data_in=0x1234... stable through BUSY.
  - dcache_data_ready pulses once; line_data_out unchanged.
- Both req asserted in the same cycle: dcache granted first. icache is served in the next transaction after dcache drops req.
- icache_req held high while dcache re-requests continuously:
  - dcache wins 3 transactions (wait_cnt 1,2,3).
  - 4th arbitration goes to icache; wait_cnt then returns to 0.
- rst asserted mid-BUSY with mem_enable=1:
  - Next cycle: all outputs 0, state IDLE, no data_ready pulse.
  - A later mem_data_ready=1 is ignored.
- mem_data_ready=1 pulsed while IDLE with no requests: no output changes, line_data_out unchanged.
